// File: rtl/led_pkg.sv
// Shared mode encoding, heartbeat pattern and pattern-level helpers for the LED blink generator.
package led_pkg;

    localparam int unsigned PHASE_W = 3;

    typedef enum logic [1:0] {
        MODE_OFF       = 2'd0,
        MODE_ON        = 2'd1,
        MODE_BLINK     = 2'd2,
        MODE_HEARTBEAT = 2'd3
    } led_mode_e;

    localparam logic [7:0] HB_PATTERN = 8'b0000_0101;

    function automatic logic mode_level(led_mode_e mode, logic [PHASE_W-1:0] phase);
        logic level;
        level = 1'b0;
        unique case (mode)
            MODE_OFF:       level = 1'b0;
            MODE_ON:        level = 1'b1;
            // Phase 0 is the high half, so the 8-phase wrap keeps the toggle seamless.
            MODE_BLINK:     level = ~phase[0];
            MODE_HEARTBEAT: level = HB_PATTERN[phase];
            default:        level = 1'b0;
        endcase
        return level;
    endfunction

    function automatic logic mode_busy(led_mode_e mode);
        return (mode == MODE_BLINK) || (mode == MODE_HEARTBEAT);
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Half-period prescaler: counts 0..half and flags the wrap cycle combinationally.
module led_prescaler #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [DIV_W-1:0] half,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick = enable && (cnt_q == half);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == half) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_blink_gen.sv
// LED pattern source: latched mode/half-period, prescaled phase sequencer, registered outputs.
// Define LED_ACTIVE_LOW_EN to invert o_led (reset, disable and pattern levels alike).
module led_blink_gen
    import led_pkg::*;
#(
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned DEFAULT_HALF = 4,
    parameter int unsigned DEFAULT_MODE = 2
) (
    input  logic             i_clock,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [1:0]       i_mode,
    input  logic [DIV_W-1:0] i_half_period,
    output logic             o_led,
    output logic             o_tick,
    output logic             o_busy
);

`ifdef LED_ACTIVE_LOW_EN
    localparam logic LED_INV = 1'b1;
`else
    localparam logic LED_INV = 1'b0;
`endif

    led_mode_e          mode_q, mode_d;
    logic [DIV_W-1:0]   half_q, half_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               led_q, led_d;
    logic               tick_q, tick_d;
    logic               busy_q, busy_d;
    logic               wrap;

    led_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clock  (i_clock),
        .reset  (~i_rst_n),
        .enable (i_enable & ~i_load),
        .clear  (i_load),
        .half   (half_q),
        .tick   (wrap)
    );

    always_comb begin
        mode_d  = mode_q;
        half_d  = half_q;
        phase_d = phase_q;
        led_d   = LED_INV;
        tick_d  = 1'b0;
        busy_d  = 1'b0;
        if (i_load) begin
            mode_d  = led_mode_e'(i_mode);
            half_d  = i_half_period;
            phase_d = '0;
            led_d   = mode_level(mode_d, '0) ^ LED_INV;
            busy_d  = i_enable && mode_busy(mode_d);
        end else if (i_enable) begin
            if (wrap) begin
                phase_d = phase_q + 1'b1;
                tick_d  = 1'b1;
            end
            // Level follows the post-edge phase, which also restores it after a disable.
            led_d  = mode_level(mode_q, phase_d) ^ LED_INV;
            busy_d = mode_busy(mode_q);
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_rst_n) begin
            mode_q  <= led_mode_e'(DEFAULT_MODE[1:0]);
            half_q  <= DEFAULT_HALF[DIV_W-1:0];
            phase_q <= '0;
            led_q   <= LED_INV;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            half_q  <= half_d;
            phase_q <= phase_d;
            led_q   <= led_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
        end
    end

    assign o_led  = led_q;
    assign o_tick = tick_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_led_blink_gen.sv
// Directed self-checking bench for led_blink_gen; expected LED levels honour LED_ACTIVE_LOW_EN.
module tb_led_blink_gen;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [1:0]  mode;
    logic [15:0] half;
    logic        led;
    logic        tick;
    logic        busy;

    int n_checks = 0;
    int n_fails  = 0;

    led_blink_gen #(
        .DIV_W        (16),
        .DEFAULT_HALF (4),
        .DEFAULT_MODE (2)
    ) dut (
        .i_clock       (clk),
        .i_rst_n       (rst_n),
        .i_enable      (enable),
        .i_load        (load),
        .i_mode        (mode),
        .i_half_period (half),
        .o_led         (led),
        .o_tick        (tick),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Checks all three outputs; exp_led is the active-high level.
    task automatic check_out(input string tag, input logic exp_led, input logic exp_tick,
                             input logic exp_busy);
        check({tag, ".led"}, led, exp_led ^ INV);
        check({tag, ".tick"}, tick, exp_tick);
        check({tag, ".busy"}, busy, exp_busy);
    endtask

    task automatic do_load(input logic [1:0] m, input logic [15:0] h);
        load = 1'b1;
        mode = m;
        half = h;
        step();
        load = 1'b0;
        mode = 2'd0;
        half = 16'hFFFF;
    endtask

    initial begin
        logic [7:0] hb;
        int ph;
        hb = 8'b0000_0101;

        rst_n  = 1'b0;
        enable = 1'b1;
        load   = 1'b0;
        mode   = 2'd0;
        half   = 16'd0;

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("reset", 1'b0, 1'b0, 1'b0);
        end

        // Defaults: BLINK, half=4 -> tick on edges 5 and 10, led 1 until edge 5, 0 until 10.
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            check_out($sformatf("dflt%0d", k), (k < 5) || (k == 10), (k % 5) == 0, 1'b1);
        end

        // BLINK half=0: tick every cycle, led 1 on load edge then 0,1,0,...
        do_load(2'd2, 16'd0);
        check_out("blink0_load", 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step();
            check_out($sformatf("blink0_%0d", k), (k % 2) == 0, 1'b1, 1'b1);
        end

        // HEARTBEAT half=1: phase after edge k is k/2, led = hb[phase].
        do_load(2'd3, 16'd1);
        check_out("hb_load", 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            step();
            ph = (k / 2) % 8;
            check_out($sformatf("hb%0d", k), hb[ph], (k % 2) == 0, 1'b1);
        end

        // ON then OFF; busy stays low. Changing inputs without load must not matter.
        do_load(2'd1, 16'd2);
        check_out("on_load", 1'b1, 1'b0, 1'b0);
        do_load(2'd0, 16'd2);
        check_out("off_load", 1'b0, 1'b0, 1'b0);
        mode = 2'd1;
        half = 16'd0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check_out($sformatf("off%0d", k), 1'b0, k == 3, 1'b0);
        end

        // BLINK half=3, run to cnt=2, disable for 10 cycles, then resume.
        do_load(2'd2, 16'd3);
        check_out("b3_load", 1'b1, 1'b0, 1'b1);
        step();
        step();
        check_out("b3_pre", 1'b1, 1'b0, 1'b1);
        enable = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check_out($sformatf("dis%0d", k), 1'b0, 1'b0, 1'b0);
        end
        enable = 1'b1;
        step();
        check_out("reen1", 1'b1, 1'b0, 1'b1);
        step();
        check_out("reen2", 1'b0, 1'b1, 1'b1);

        // cnt=0, phase=1; advance to cnt==3 then load HEARTBEAT half=5 on the wrap cycle.
        for (int k = 1; k <= 3; k++) begin
            step();
            check_out($sformatf("pre_coinc%0d", k), 1'b0, 1'b0, 1'b1);
        end
        do_load(2'd3, 16'd5);
        check_out("coinc_load", 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            step();
            check_out($sformatf("coinc%0d", k), k < 6, k == 6, 1'b1);
        end

        // Reset mid-run returns outputs to idle levels.
        rst_n = 1'b0;
        step();
        check_out("reset2", 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
